// File: rtl/jtdsp16_sio_pkg.sv
// Shared FSM encodings and the serial bit-select helper for the DSP16 SIO output unit.
// Pure definitions, no state.
package jtdsp16_sio_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    localparam int SIO_MAXW = 32;

    // idx counts transmitted bits from 0; dw is the full-mode word length
    function automatic logic bitsel(
        input logic [SIO_MAXW-1:0] word,
        input logic [5:0]          idx,
        input logic                msb_first,
        input logic                mode8,
        input logic [5:0]          dw = 6'd32
    );
        logic [5:0] len;
        logic [5:0] pos;
        len = mode8 ? 6'd8 : dw;
        pos = msb_first ? (len - 6'd1 - idx) : idx;
        return word[pos[4:0]];
    endfunction

endpackage

// File: rtl/jtdsp16_sio_wfifo.sv
// Write FIFO for the SIO output unit, head word visible combinationally.
// Latency: a push is visible at head/count after one clk; pop takes effect the same edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module jtdsp16_sio_wfifo #(
    parameter int DW = 16,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam int DEPTH = 1 << AW;
    localparam int CNTW  = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNTW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CNTW'(1);
            else if (do_pop && !do_push)
                count <= count - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/jtdsp16_sio_fifo.sv
// DSP16 serial output unit: write FIFO, 8/16-bit words, OCK = cen/(2*CKDIV); JTDSP16_SIO_RX_EN adds the rx path.
// Latency: a write into an idle, empty unit drives old and the first bit on the next cen edge.
// Backpressure: full flags the FIFO; writes while full without a pop are dropped and set ovf.
module jtdsp16_sio_fifo
    import jtdsp16_sio_pkg::*;
#(
    parameter int DW    = 16,
    parameter int AW    = 2,
    parameter int CKDIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          wr,
    input  logic [DW-1:0] din,
    input  logic          mode8,
    input  logic          msb_first,
    input  logic          ovf_clr,
    input  logic          doen,
`ifdef JTDSP16_SIO_RX_EN
    input  logic          ick,
    input  logic          di,
    input  logic          ild,
    input  logic          rd,
    output logic [DW-1:0] rx_dout,
    output logic          ibf,
    output logic          rx_ovr,
`endif
    output logic          full,
    output logic          obe,
    output logic          ovf,
    output logic          ock,
    output logic          sdo,
    output logic          sdo_oe,
    output logic          old,
    output logic          ose
);
    localparam int CW  = $clog2(DW + 1);
    localparam int DVW = (CKDIV > 1) ? $clog2(CKDIV) : 1;

    logic [1:0]          st;
    logic [DVW-1:0]      div;
    logic [DW-1:0]       word_r;
    logic [DW-1:0]       head;
    logic [CW-1:0]       bitcnt;
    logic [CW-1:0]       len_r;
    logic [CW-1:0]       load_len;
    logic [CW-1:0]       nxt_idx;
    logic                m8_r;
    logic                msb_r;
    logic                empty;
    logic [AW:0]         count;
    logic                wrap;
    logic                fall;
    logic                last;
    logic                pop;
    logic                push;
    logic [SIO_MAXW-1:0] head_ext;
    logic [SIO_MAXW-1:0] word_ext;

    jtdsp16_sio_wfifo #(.DW(DW), .AW(AW)) u_wfifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign wrap     = cen && (st != ST_IDLE) && (div == DVW'(CKDIV - 1));
    assign fall     = wrap & ock;
    assign last     = fall & (bitcnt == CW'(1));
    // a finishing word pops its successor in the same tick, so frames abut
    assign pop      = cen & ~empty & ((st == ST_IDLE) | last);
    assign push     = wr & cen;
    assign load_len = mode8 ? CW'(8) : CW'(DW);
    assign nxt_idx  = len_r - bitcnt + CW'(1);

    always_comb begin
        head_ext           = '0;
        head_ext[DW-1:0]   = head;
        word_ext           = '0;
        word_ext[DW-1:0]   = word_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= ST_IDLE;
            div    <= '0;
            ock    <= 1'b0;
            sdo    <= 1'b0;
            word_r <= '0;
            bitcnt <= '0;
            len_r  <= '0;
            m8_r   <= 1'b0;
            msb_r  <= 1'b0;
            ovf    <= 1'b0;
        end else if (cen) begin
            if (wr && full && !pop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;

            if (st == ST_IDLE) begin
                div <= '0;
                ock <= 1'b0;
            end else begin
                div <= wrap ? '0 : div + DVW'(1);
                if (wrap) ock <= ~ock;
            end

            if (pop) begin
                st     <= ST_LOAD;
                word_r <= head;
                m8_r   <= mode8;
                msb_r  <= msb_first;
                bitcnt <= load_len;
                len_r  <= load_len;
                sdo    <= bitsel(head_ext, 6'd0, msb_first, mode8, 6'(DW));
            end else if (last) begin
                st  <= ST_IDLE;
                sdo <= 1'b0;
            end else if (fall) begin
                st     <= ST_SHIFT;
                bitcnt <= bitcnt - CW'(1);
                sdo    <= bitsel(word_ext, 6'(nxt_idx), msb_r, m8_r, 6'(DW));
            end
        end
    end

    assign ose    = (st == ST_IDLE);
    assign old    = (st == ST_LOAD);
    assign sdo_oe = doen & ~ose;
    assign obe    = (count == '0);

`ifdef JTDSP16_SIO_RX_EN
    logic [2:0]    ick_s;
    logic [2:0]    ild_s;
    logic [1:0]    di_s;
    logic [DW-1:0] rx_sh;

    // di travels the same two flops as ick so the sample lines up with the edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ick_s   <= '0;
            ild_s   <= '0;
            di_s    <= '0;
            rx_sh   <= '0;
            rx_dout <= '0;
            ibf     <= 1'b0;
            rx_ovr  <= 1'b0;
        end else begin
            ick_s <= {ick_s[1:0], ick};
            ild_s <= {ild_s[1:0], ild};
            di_s  <= {di_s[0], di};
            if (ick_s[1] && !ick_s[2])
                rx_sh <= {rx_sh[DW-2:0], di_s[1]};
            if (ild_s[1] && !ild_s[2]) begin
                rx_dout <= rx_sh;
                ibf     <= 1'b1;
                if (ibf) rx_ovr <= 1'b1;
            end else if (rd && cen) begin
                ibf    <= 1'b0;
                rx_ovr <= 1'b0;
            end
        end
    end
`endif

endmodule
